// File: rtl/cdc_fifo_write_arbiter_if.sv
// Producer-side handshake and FIFO write-port bundle for the CDC FIFO write arbiter.
// The master modport is the arbiter's view; the slave modport is the producers/FIFO view.
interface cdc_fifo_write_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ID_WIDTH       = 2
);
  logic [NUM_REQUESTERS-1:0]            request_valid;
  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] request_data;
  logic [NUM_REQUESTERS-1:0]            request_last;
  logic [NUM_REQUESTERS-1:0]            request_ready;
  logic [ID_WIDTH+DATA_WIDTH-1:0]       fifo_write_data;
  logic                                 fifo_write_increment;
  logic                                 fifo_full;
  logic [ID_WIDTH-1:0]                  grant_id;
  logic                                 busy;

  modport master (
    input  request_valid, request_data, request_last, fifo_full,
    output request_ready, fifo_write_data, fifo_write_increment, grant_id, busy
  );

  modport slave (
    output request_valid, request_data, request_last, fifo_full,
    input  request_ready, fifo_write_data, fifo_write_increment, grant_id, busy
  );
endinterface

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one CDC FIFO write port among several
// producers; each pushed word carries the granted requester's ID in its top bits.
module cdc_fifo_write_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ID_WIDTH       = 2,
  parameter int MAX_BURST      = 4
) (
  input logic                      clock,
  input logic                      reset,
  cdc_fifo_write_arbiter_if.master bus
);
  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] grant_q, grant_nxt;
  logic [ID_WIDTH-1:0] last_grant, last_nxt;
  logic [ID_WIDTH-1:0] pick, cand;
  logic [BEAT_W-1:0]   beat_count, beat_nxt;
  logic [DATA_WIDTH-1:0] g_data;
  logic                g_valid, g_last, xfer;

  // Wraps modulo NUM_REQUESTERS, not 2^ID_WIDTH, so non-power-of-two counts work.
  function automatic int rr_index(input int base, input int off);
    int s;
    s = base + 1 + off;
    if (s >= NUM_REQUESTERS) s = s - NUM_REQUESTERS;
    return s;
  endfunction

  // Reverse scan so the lowest offset from last_grant+1 wins the overwrite.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      cand = ID_WIDTH'(rr_index(int'(last_grant), i));
      if (bus.request_valid[cand]) pick = cand;
    end
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_q == ID_WIDTH'(i)) g_data = bus.request_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign g_valid = bus.request_valid[grant_q];
  assign g_last  = bus.request_last[grant_q];
  assign xfer    = (state == GRANT) && g_valid && !bus.fifo_full;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last_grant;
    beat_nxt  = beat_count;
    case (state)
      IDLE: begin
        if (|bus.request_valid) begin
          state_nxt = GRANT;
          grant_nxt = pick;
          last_nxt  = pick;
          beat_nxt  = '0;
        end
      end
      GRANT: begin
        // A dropped valid forfeits the grant even while the FIFO is full.
        if (!g_valid) begin
          state_nxt = IDLE;
        end else if (xfer) begin
          if (g_last || beat_count == BEAT_W'(MAX_BURST - 1)) state_nxt = IDLE;
          else beat_nxt = beat_count + BEAT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= ID_WIDTH'(NUM_REQUESTERS - 1);
      beat_count <= '0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      last_grant <= last_nxt;
      beat_count <= beat_nxt;
    end
  end

  always_comb begin
    bus.request_ready        = '0;
    bus.fifo_write_increment = 1'b0;
    if (state == GRANT && !bus.fifo_full) begin
      bus.request_ready        = NUM_REQUESTERS'(1) << grant_q;
      bus.fifo_write_increment = g_valid;
    end
  end

  assign bus.fifo_write_data = {grant_q, g_data};
  assign bus.grant_id        = grant_q;
  assign bus.busy            = (state == GRANT);
endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Directed bench for cdc_fifo_write_arbiter: reset, round robin, burst cap,
// FIFO-full stall, valid drop and asynchronous reset in mid-burst.
module tb_cdc_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int MB = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cdc_fifo_write_arbiter_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  cdc_fifo_write_arbiter #(
    .NUM_REQUESTERS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(MB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int w   [N];
  int lim [N];
  logic [7:0] base [N];
  logic       lst  [N];
  logic [N-1:0] acc;
  int incs;

  int t3_inc  [14] = '{1,1,1,1,0,1,1,1,1,0,1,1,0,0};
  int t3_busy [14] = '{1,1,1,1,0,1,1,1,1,0,1,1,1,0};
  int t3_data [14] = '{'h250,'h251,'h252,'h253,0,'h254,'h255,'h256,'h257,0,'h258,'h259,0,0};
  int rr_gnt  [4]  = '{1,2,3,0};
  int rr_data [4]  = '{'h1B0,'h2C0,'h3D0,'h0A1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.request_valid[i]         = (w[i] < lim[i]);
      bus.request_data[i*DW +: DW] = base[i] + 8'(w[i]);
      bus.request_last[i]          = lst[i];
    end
  endtask

  task automatic set_req(input int i, input int l, input logic [7:0] b, input logic la);
    w[i]    = 0;
    lim[i]  = l;
    base[i] = b;
    lst[i]  = la;
  endtask

  // Producers advance to their next word only when the edge accepted the current one.
  task automatic tick();
    @(negedge clock);
    acc = bus.request_valid & bus.request_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) w[i]++;
    apply();
    #1;
  endtask

  task automatic chk_out(input string tag, input int busy, input int inc, input int rdy,
                         input int gnt, input int data);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(busy));
    chk({tag, "_inc"},  32'(bus.fifo_write_increment), 32'(inc));
    chk({tag, "_ready"}, 32'(bus.request_ready), 32'(rdy));
    chk({tag, "_gnt"},  32'(bus.grant_id), 32'(gnt));
    chk({tag, "_data"}, 32'(bus.fifo_write_data), 32'(data));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    bus.fifo_full = 1'b0;
    set_req(0, 255, 8'hA0, 1'b1);
    set_req(1, 255, 8'hB0, 1'b1);
    set_req(2, 255, 8'hC0, 1'b1);
    set_req(3, 255, 8'hD0, 1'b1);
    apply();

    // Reset held with every requester valid.
    #2;
    chk_out("rst", 0, 0, 0, 0, 'h0A0);
    tick();
    chk_out("rst_edge", 0, 0, 0, 0, 'h0A0);
    #1 reset = 1'b1;
    #1;
    chk("rel_busy", 32'(bus.busy), 0);
    chk("rel_inc", 32'(bus.fifo_write_increment), 0);
    tick();
    chk_out("first_grant", 1, 1, 'b0001, 0, 'h0A0);
    tick();
    chk_out("first_release", 0, 0, 0, 0, 'h0A1);

    // Round robin, last on every word: one word then one idle bubble per grant.
    incs = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr%0d_gnt", k), 32'(bus.grant_id), 32'(rr_gnt[k]));
      chk($sformatf("rr%0d_data", k), 32'(bus.fifo_write_data), 32'(rr_data[k]));
      chk($sformatf("rr%0d_busy", k), 32'(bus.busy), 1);
      incs += int'(bus.fifo_write_increment);
      tick();
      chk($sformatf("rr%0d_idle", k), 32'(bus.busy), 0);
      incs += int'(bus.fifo_write_increment);
    end
    chk("rr_words_in_8", 32'(incs), 4);
    for (int i = 0; i < N; i++) lim[i] = w[i];
    apply();

    // Burst cap: requester 2 alone sends 10 words, last never set.
    set_req(2, 10, 8'h50, 1'b0);
    apply();
    for (int c = 0; c < 14; c++) begin
      tick();
      chk($sformatf("burst%0d_inc", c), 32'(bus.fifo_write_increment), 32'(t3_inc[c]));
      chk($sformatf("burst%0d_busy", c), 32'(bus.busy), 32'(t3_busy[c]));
      if (t3_inc[c] != 0)
        chk($sformatf("burst%0d_data", c), 32'(bus.fifo_write_data), 32'(t3_data[c]));
    end
    chk("burst_total", 32'(w[2]), 10);

    // FIFO full for 5 cycles in the middle of a 4-word burst from requester 1.
    set_req(1, 4, 8'h70, 1'b0);
    apply();
    tick();
    chk_out("full_grant", 1, 1, 'b0010, 1, 'h170);
    tick();
    chk_out("full_w1", 1, 1, 'b0010, 1, 'h171);
    bus.fifo_full = 1'b1;
    #1;
    chk_out("full_on", 1, 0, 0, 1, 'h171);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_out($sformatf("stall%0d", c), 1, 0, 0, 1, 'h171);
    end
    bus.fifo_full = 1'b0;
    #1;
    chk_out("resume_w1", 1, 1, 'b0010, 1, 'h171);
    tick();
    chk_out("resume_w2", 1, 1, 'b0010, 1, 'h172);
    tick();
    chk_out("resume_w3", 1, 1, 'b0010, 1, 'h173);
    tick();
    chk("full_release", 32'(bus.busy), 0);
    chk("full_total", 32'(w[1]), 4);

    // Requester 1 drops valid after one word; requester 2 wins the next round.
    set_req(1, 1, 8'h90, 1'b0);
    apply();
    tick();
    chk_out("drop_grant", 1, 1, 'b0010, 1, 'h190);
    tick();
    chk_out("drop_novalid", 1, 0, 'b0010, 1, 'h191);
    tick();
    chk("drop_release", 32'(bus.busy), 0);
    set_req(1, 5, 8'h90, 1'b0);
    set_req(2, 5, 8'hE0, 1'b0);
    apply();
    tick();
    chk_out("drop_next", 1, 1, 'b0100, 2, 'h2E0);

    // Requester 0 raises valid mid-grant and is ignored; then async reset mid-burst.
    set_req(0, 5, 8'h40, 1'b0);
    apply();
    #1;
    chk("ignore_gnt", 32'(bus.grant_id), 2);
    tick();
    chk_out("ignore_w1", 1, 1, 'b0100, 2, 'h2E1);
    #1 reset = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 'h040);
    tick();
    chk_out("async_rst_edge", 0, 0, 0, 0, 'h040);
    #1 reset = 1'b1;
    #1;
    chk_out("async_rel", 0, 0, 0, 0, 'h040);
    tick();
    chk_out("async_regrant", 1, 1, 'b0001, 0, 'h040);
    chk("async_w2_count", 32'(w[2]), 1);
    chk("async_w0_count", 32'(w[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
